arp_reply_receiver: RTL and testbench

// - Consumer of the ARP block's transmit stream on the CLK_TX domain: accepts one 42-byte ARP frame per

---
 rtl/arp_reply_receiver.sv | 216 +++++++++++++++++++++
 tb/tb_arp_reply_receiver.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_reply_receiver.sv
// -----------------------------------------------------------------------------
// arp_reply_receiver
//
// Purpose:
//   Receives the ARP block's transmit stream on CLK_TX. It accepts one frame per
//   DATA_VALID_TX/DATA_ACK_TX handshake and parses the frame as bytes arrive.
//   It then classifies the frame as a good ARP reply addressed to us or as a
//   dropped frame with a reason code. Good replies publish the sender MAC/IPv4
//   pair to the host ARP table.
//
// Optional feature:
//   `ARP_RX_STATS_EN  - when defined, GOOD_CNT/DROP_CNT are saturating counters.
//                       When undefined, both outputs are tied to 0.
//
// Ports:
//   CLK_TX         in   transmit-side byte clock (rising edge)
//   ARESET         in   asynchronous active-high reset
//   MY_MAC/MY_IPV4 in   local addresses (quasi-static)
//   ENABLE         in   permits acceptance of a new frame
//   DATA_VALID_TX  in   frame-valid, high for every byte of a frame
//   DATA_TX        in   frame byte, network order
//   DATA_ACK_TX    out  accept strobe for the first byte (combinational)
//   BUSY           out  frame in progress or being judged
//   REPLY_VALID    out  one-cycle pulse: good reply, REPLY_MAC/REPLY_IP updated
//   REPLY_MAC/IP   out  sender addresses of the last good reply
//   DROP           out  one-cycle pulse: frame rejected, DROP_CODE updated
//   DROP_CODE      out  1 length, 2 header, 3 opcode, 4 MAC, 5 target IP
//   GOOD_CNT       out  saturating count of good replies
//   DROP_CNT       out  saturating count of dropped frames
// -----------------------------------------------------------------------------
module arp_reply_receiver #(
    parameter int PKT_BYTES = 42,
    parameter int CNT_W     = 16
) (
    input  logic             CLK_TX,
    input  logic             ARESET,
    input  logic [47:0]      MY_MAC,
    input  logic [31:0]      MY_IPV4,
    input  logic             ENABLE,
    input  logic             DATA_VALID_TX,
    input  logic [7:0]       DATA_TX,
    output logic             DATA_ACK_TX,
    output logic             BUSY,
    output logic             REPLY_VALID,
    output logic [47:0]      REPLY_MAC,
    output logic [31:0]      REPLY_IP,
    output logic             DROP,
    output logic [2:0]       DROP_CODE,
    output logic [CNT_W-1:0] GOOD_CNT,
    output logic [CNT_W-1:0] DROP_CNT
);

    typedef enum logic [1:0] {S_IDLE, S_RECEIVE, S_CHECK} state_t;

    state_t      state, state_nxt;
    logic [5:0]  idx;
    logic        hdr_err, op_err, mac_err, ip_err;
    logic [47:0] shadow_mac;
    logic [31:0] shadow_ip;

    logic        cap;
    logic [5:0]  cur_idx;
    logic [7:0]  exp_byte;
    logic        chk_hdr, chk_op, chk_mac, chk_ip, mismatch;

    logic        good_c, drop_c;
    logic [2:0]  code_c;

    // State register
    always_ff @(posedge CLK_TX or posedge ARESET) begin
        if (ARESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (DATA_ACK_TX)    state_nxt = S_RECEIVE;
            S_RECEIVE: if (!DATA_VALID_TX) state_nxt = S_CHECK;
            S_CHECK:                       state_nxt = S_IDLE;
            default:                       state_nxt = S_IDLE;
        endcase
    end

    // Output logic: handshake, busy and the verdict formed during CHECK.
    // Lowest code wins on multiple faults.
    always_comb begin
        DATA_ACK_TX = (state == S_IDLE) && DATA_VALID_TX && ENABLE;
        BUSY        = (state != S_IDLE);
        good_c      = 1'b0;
        drop_c      = 1'b0;
        code_c      = 3'd0;
        if (state == S_CHECK) begin
            drop_c = 1'b1;
            if (idx != 6'(PKT_BYTES)) code_c = 3'd1;
            else if (hdr_err)         code_c = 3'd2;
            else if (op_err)          code_c = 3'd3;
            else if (mac_err)         code_c = 3'd4;
            else if (ip_err)          code_c = 3'd5;
            else begin
                drop_c = 1'b0;
                good_c = 1'b1;
            end
        end
    end

    // Byte classifier: the byte on DATA_TX belongs to index 0 while idle (the
    // acked byte) and to the running index otherwise. Bytes past PKT_BYTES
    // are absorbed without being compared or stored.
    always_comb begin
        cap      = DATA_ACK_TX || ((state == S_RECEIVE) && DATA_VALID_TX);
        cur_idx  = (state == S_IDLE) ? 6'd0 : idx;
        exp_byte = 8'h00;
        chk_hdr  = 1'b0;
        chk_op   = 1'b0;
        chk_mac  = 1'b0;
        chk_ip   = 1'b0;
        if (cur_idx < 6'(PKT_BYTES)) begin
            case (cur_idx)
                6'd0,  6'd32: begin chk_mac = 1'b1; exp_byte = MY_MAC[47:40]; end
                6'd1,  6'd33: begin chk_mac = 1'b1; exp_byte = MY_MAC[39:32]; end
                6'd2,  6'd34: begin chk_mac = 1'b1; exp_byte = MY_MAC[31:24]; end
                6'd3,  6'd35: begin chk_mac = 1'b1; exp_byte = MY_MAC[23:16]; end
                6'd4,  6'd36: begin chk_mac = 1'b1; exp_byte = MY_MAC[15:8];  end
                6'd5,  6'd37: begin chk_mac = 1'b1; exp_byte = MY_MAC[7:0];   end
                6'd12: begin chk_hdr = 1'b1; exp_byte = 8'h08; end
                6'd13: begin chk_hdr = 1'b1; exp_byte = 8'h06; end
                6'd14: begin chk_hdr = 1'b1; exp_byte = 8'h00; end
                6'd15: begin chk_hdr = 1'b1; exp_byte = 8'h01; end
                6'd16: begin chk_hdr = 1'b1; exp_byte = 8'h08; end
                6'd17: begin chk_hdr = 1'b1; exp_byte = 8'h00; end
                6'd18: begin chk_hdr = 1'b1; exp_byte = 8'h06; end
                6'd19: begin chk_hdr = 1'b1; exp_byte = 8'h04; end
                6'd20: begin chk_op  = 1'b1; exp_byte = 8'h00; end
                6'd21: begin chk_op  = 1'b1; exp_byte = 8'h02; end
                6'd38: begin chk_ip  = 1'b1; exp_byte = MY_IPV4[31:24]; end
                6'd39: begin chk_ip  = 1'b1; exp_byte = MY_IPV4[23:16]; end
                6'd40: begin chk_ip  = 1'b1; exp_byte = MY_IPV4[15:8];  end
                6'd41: begin chk_ip  = 1'b1; exp_byte = MY_IPV4[7:0];   end
                default: ;
            endcase
        end
        mismatch = (DATA_TX != exp_byte);
    end

    // Byte index and sticky error flags; the acked byte restarts them fresh
    always_ff @(posedge CLK_TX or posedge ARESET) begin
        if (ARESET) begin
            idx     <= 6'd0;
            hdr_err <= 1'b0;
            op_err  <= 1'b0;
            mac_err <= 1'b0;
            ip_err  <= 1'b0;
        end else if (DATA_ACK_TX) begin
            idx     <= 6'd1;
            hdr_err <= chk_hdr && mismatch;
            op_err  <= chk_op  && mismatch;
            mac_err <= chk_mac && mismatch;
            ip_err  <= chk_ip  && mismatch;
        end else if (cap) begin
            if (idx != 6'd63) idx <= idx + 6'd1;
            hdr_err <= hdr_err || (chk_hdr && mismatch);
            op_err  <= op_err  || (chk_op  && mismatch);
            mac_err <= mac_err || (chk_mac && mismatch);
            ip_err  <= ip_err  || (chk_ip  && mismatch);
        end
    end

    // Sender fields arrive in order, so they are shifted in
    always_ff @(posedge CLK_TX) begin
        if (cap && (cur_idx >= 6'd22) && (cur_idx <= 6'd27) && (cur_idx < 6'(PKT_BYTES)))
            shadow_mac <= {shadow_mac[39:0], DATA_TX};
        if (cap && (cur_idx >= 6'd28) && (cur_idx <= 6'd31) && (cur_idx < 6'(PKT_BYTES)))
            shadow_ip <= {shadow_ip[23:0], DATA_TX};
    end

    // Verdict registers: pulses and held results appear one cycle after CHECK
    always_ff @(posedge CLK_TX or posedge ARESET) begin
        if (ARESET) begin
            REPLY_VALID <= 1'b0;
            DROP        <= 1'b0;
            REPLY_MAC   <= 48'd0;
            REPLY_IP    <= 32'd0;
            DROP_CODE   <= 3'd0;
        end else begin
            REPLY_VALID <= good_c;
            DROP        <= drop_c;
            if (good_c) begin
                REPLY_MAC <= shadow_mac;
                REPLY_IP  <= shadow_ip;
            end
            if (drop_c) DROP_CODE <= code_c;
        end
    end

`ifdef ARP_RX_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge CLK_TX or posedge ARESET) begin
        if (ARESET) begin
            GOOD_CNT <= '0;
            DROP_CNT <= '0;
        end else begin
            if (good_c) GOOD_CNT <= sat_inc(GOOD_CNT);
            if (drop_c) DROP_CNT <= sat_inc(DROP_CNT);
        end
    end
`else
    assign GOOD_CNT = '0;
    assign DROP_CNT = '0;
`endif

endmodule

// File: tb/tb_arp_reply_receiver.sv
module tb_arp_reply_receiver;

    localparam int TB_CNT_W = 2;

    logic        clk = 1'b0;
    logic        areset;
    logic [47:0] my_mac;
    logic [31:0] my_ip;
    logic        en;
    logic        dv;
    logic [7:0]  data;

    logic                DATA_ACK_TX, BUSY, REPLY_VALID, DROP;
    logic [47:0]         REPLY_MAC;
    logic [31:0]         REPLY_IP;
    logic [2:0]          DROP_CODE;
    logic [TB_CNT_W-1:0] GOOD_CNT, DROP_CNT;

    int passed = 0;
    int total  = 0;

    arp_reply_receiver #(.PKT_BYTES(42), .CNT_W(TB_CNT_W)) dut (
        .CLK_TX       (clk),
        .ARESET       (areset),
        .MY_MAC       (my_mac),
        .MY_IPV4      (my_ip),
        .ENABLE       (en),
        .DATA_VALID_TX(dv),
        .DATA_TX      (data),
        .DATA_ACK_TX  (DATA_ACK_TX),
        .BUSY         (BUSY),
        .REPLY_VALID  (REPLY_VALID),
        .REPLY_MAC    (REPLY_MAC),
        .REPLY_IP     (REPLY_IP),
        .DROP         (DROP),
        .DROP_CODE    (DROP_CODE),
        .GOOD_CNT     (GOOD_CNT),
        .DROP_CNT     (DROP_CNT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    // ---------------- behavioural model ----------------
    // Frame-level view: collect the accepted bytes, judge the complete frame
    // by its field values, publish the verdict one cycle after the judging cycle.
    logic [7:0]          mq[$];
    int                  m_phase = 0;   // 0 waiting for frame, 1 in frame, 2 judging
    logic                m_rv = 0, m_drop = 0;
    logic [47:0]         m_mac = 0;
    logic [31:0]         m_ip = 0;
    logic [2:0]          m_code = 0;
    logic [TB_CNT_W-1:0] m_gcnt = 0, m_dcnt = 0;

    function automatic int judge();
        logic [47:0] dmac, tmac;
        logic [31:0] tip;
        if (mq.size() != 42) return 1;
        if ({mq[12], mq[13]} != 16'h0806 || {mq[14], mq[15]} != 16'h0001 ||
            {mq[16], mq[17]} != 16'h0800 || mq[18] != 8'h06 || mq[19] != 8'h04) return 2;
        if ({mq[20], mq[21]} != 16'h0002) return 3;
        dmac = {mq[0], mq[1], mq[2], mq[3], mq[4], mq[5]};
        tmac = {mq[32], mq[33], mq[34], mq[35], mq[36], mq[37]};
        if (dmac != my_mac || tmac != my_mac) return 4;
        tip = {mq[38], mq[39], mq[40], mq[41]};
        if (tip != my_ip) return 5;
        return 0;
    endfunction

    always @(posedge clk or posedge areset) begin
        if (areset) begin
            m_phase = 0; mq.delete();
            m_rv = 0; m_drop = 0; m_mac = 0; m_ip = 0; m_code = 0;
            m_gcnt = 0; m_dcnt = 0;
        end else begin
            int v;
            m_rv = 0; m_drop = 0;
            if (m_phase == 0) begin
                if (dv && en) begin mq.delete(); mq.push_back(data); m_phase = 1; end
            end else if (m_phase == 1) begin
                if (dv) mq.push_back(data);
                else    m_phase = 2;
            end else begin
                v = judge();
                if (v == 0) begin
                    m_rv  = 1;
                    m_mac = {mq[22], mq[23], mq[24], mq[25], mq[26], mq[27]};
                    m_ip  = {mq[28], mq[29], mq[30], mq[31]};
`ifdef ARP_RX_STATS_EN
                    if (m_gcnt != '1) m_gcnt = m_gcnt + 1'b1;
`endif
                end else begin
                    m_drop = 1;
                    m_code = v[2:0];
`ifdef ARP_RX_STATS_EN
                    if (m_dcnt != '1) m_dcnt = m_dcnt + 1'b1;
`endif
                end
                m_phase = 0;
            end
        end
    end

    // Compare process, mid-cycle
    always @(negedge clk) begin
        chk("ack",         DATA_ACK_TX, (m_phase == 0) && dv && en);
        chk("busy",        BUSY,        m_phase != 0);
        chk("reply_valid", REPLY_VALID, m_rv);
        chk("drop",        DROP,        m_drop);
        chk("drop_code",   DROP_CODE,   m_code);
        chk("reply_mac",   REPLY_MAC,   m_mac);
        chk("reply_ip",    REPLY_IP,    m_ip);
        chk("good_cnt",    GOOD_CNT,    m_gcnt);
        chk("drop_cnt",    DROP_CNT,    m_dcnt);
    end

    // ---------------- stimulus ----------------
    logic [7:0] frm [0:63];

    task automatic build(input logic [47:0] smac, input logic [31:0] sip,
                         input logic [15:0] op, input logic [31:0] tip);
        for (int i = 0; i < 64; i++) frm[i] = 8'hAA;
        for (int i = 0; i < 6; i++) begin
            frm[i]      = my_mac[8*(5-i) +: 8];
            frm[6 + i]  = smac[8*(5-i) +: 8];
            frm[22 + i] = smac[8*(5-i) +: 8];
            frm[32 + i] = my_mac[8*(5-i) +: 8];
        end
        frm[12] = 8'h08; frm[13] = 8'h06; frm[14] = 8'h00; frm[15] = 8'h01;
        frm[16] = 8'h08; frm[17] = 8'h00; frm[18] = 8'h06; frm[19] = 8'h04;
        frm[20] = op[15:8]; frm[21] = op[7:0];
        for (int i = 0; i < 4; i++) begin
            frm[28 + i] = sip[8*(3-i) +: 8];
            frm[38 + i] = tip[8*(3-i) +: 8];
        end
    endtask

    task automatic send_frame(input int n);
        int waitc = 0;
        @(posedge clk); #1; dv = 1'b1; data = frm[0];
        @(negedge clk);
        while (!DATA_ACK_TX && waitc < 200) begin @(negedge clk); waitc++; end
        if (waitc >= 200) begin
            total++;
            $display("FAIL ack_timeout: no DATA_ACK_TX within 200 cycles, required ack");
            @(posedge clk); #1; dv = 1'b0;
            return;
        end
        for (int i = 1; i < n; i++) begin @(posedge clk); #1; data = (i < 64) ? frm[i] : 8'h55; end
        @(posedge clk); #1; dv = 1'b0; data = 8'h00;
    endtask

    // Counts mid-cycle samples from the drop of DATA_VALID_TX to the verdict pulse
    task automatic wait_result(output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!(REPLY_VALID || DROP) && lat < 10);
    endtask

    int lat;

    initial begin
        areset = 1'b1; dv = 1'b0; en = 1'b1; data = 8'h00;
        my_mac = 48'h000223010203;
        my_ip  = 32'hc0a80102;
        repeat (3) @(posedge clk);
        #1 areset = 1'b0;
        @(negedge clk);
        chk("rst_busy",  BUSY, 0);
        chk("rst_mac",   REPLY_MAC, 0);
        chk("rst_code",  DROP_CODE, 0);
        chk("rst_gcnt",  GOOD_CNT, 0);

        // Good reply
        build(48'h000142005f68, 32'hc0a80101, 16'h0002, 32'hc0a80102);
        send_frame(42); wait_result(lat);
        chk("good_latency", lat, 3);
        chk("good_rv",  REPLY_VALID, 1);
        chk("good_mac", REPLY_MAC, 48'h000142005f68);
        chk("good_ip",  REPLY_IP, 32'hc0a80101);

        // Opcode request -> code 3, reply fields held
        build(48'h000142005f68, 32'hc0a80101, 16'h0001, 32'hc0a80102);
        send_frame(42); wait_result(lat);
        chk("op_drop", DROP, 1);
        chk("op_code", DROP_CODE, 3);
        chk("op_mac_held", REPLY_MAC, 48'h000142005f68);
        chk("op_ip_held",  REPLY_IP, 32'hc0a80101);

        // Target IP mismatch -> 5
        build(48'h000142005f68, 32'hc0a80101, 16'h0002, 32'hdddddddd);
        send_frame(42); wait_result(lat);
        chk("tip_code", DROP_CODE, 5);

        // Short frame -> 1
        build(48'h000142005f68, 32'hc0a80101, 16'h0002, 32'hc0a80102);
        send_frame(41); wait_result(lat);
        chk("short_code", DROP_CODE, 1);

        // Long frame -> 1, then a different good frame still parses
        send_frame(50); wait_result(lat);
        chk("long_drop", DROP, 1);
        chk("long_code", DROP_CODE, 1);
        build(48'h001122334455, 32'hc0a80163, 16'h0002, 32'hc0a80102);
        send_frame(42); wait_result(lat);
        chk("after_long_mac", REPLY_MAC, 48'h001122334455);
        chk("after_long_ip",  REPLY_IP, 32'hc0a80163);

        // Bad hlen and bad opcode together -> header code 2 wins
        build(48'h000142005f68, 32'hc0a80101, 16'h0001, 32'hc0a80102);
        frm[18] = 8'h08;
        send_frame(42); wait_result(lat);
        chk("multi_code", DROP_CODE, 2);

        // Target MAC mismatch -> 4; dest MAC plus target IP -> 4
        build(48'h000142005f68, 32'hc0a80101, 16'h0002, 32'hc0a80102);
        frm[33] = 8'hff;
        send_frame(42); wait_result(lat);
        chk("tmac_code", DROP_CODE, 4);
        build(48'h000142005f68, 32'hc0a80101, 16'h0002, 32'h01020304);
        frm[0] = 8'h99;
        send_frame(42); wait_result(lat);
        chk("dmac_tip_code", DROP_CODE, 4);

        // ENABLE low stalls the frame; ack appears the cycle ENABLE rises
        build(48'h0000000000aa, 32'h0a000001, 16'h0002, 32'hc0a80102);
        @(posedge clk); #1; en = 1'b0; dv = 1'b1; data = frm[0];
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0 || i == 19) chk("stall_ack", DATA_ACK_TX, 0);
        end
        @(posedge clk); #1; en = 1'b1;
        @(negedge clk);
        chk("enable_ack", DATA_ACK_TX, 1);
        for (int i = 1; i < 42; i++) begin @(posedge clk); #1; data = frm[i]; end
        @(posedge clk); #1; dv = 1'b0;
        wait_result(lat);
        chk("enable_mac", REPLY_MAC, 48'h0000000000aa);

        // Reset in the middle of a frame
        build(48'h000142005f68, 32'hc0a80101, 16'h0002, 32'hc0a80102);
        @(posedge clk); #1; dv = 1'b1; data = frm[0];
        for (int i = 1; i <= 20; i++) begin @(posedge clk); #1; data = frm[i]; end
        areset = 1'b1; dv = 1'b0;
        repeat (2) @(posedge clk);
        #1 areset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid_pulse", {REPLY_VALID, DROP}, 2'b00);
        end
        chk("rst_mid_mac", REPLY_MAC, 0);

        // Five good frames then one bad: counters saturate in the stats build
        for (int k = 0; k < 5; k++) begin
            build(48'h000142005f68, 32'hc0a80101, 16'h0002, 32'hc0a80102);
            send_frame(42); wait_result(lat);
            chk("post_rst_good", REPLY_VALID, 1);
        end
        build(48'h000142005f68, 32'hc0a80101, 16'h0001, 32'hc0a80102);
        send_frame(42); wait_result(lat);
        repeat (2) @(negedge clk);
`ifdef ARP_RX_STATS_EN
        chk("good_cnt_sat", GOOD_CNT, 3);
        chk("drop_cnt_one", DROP_CNT, 1);
`else
        chk("good_cnt_tied", GOOD_CNT, 0);
        chk("drop_cnt_tied", DROP_CNT, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
